// File: rtl/misr_resp_collector.sv
// misr_resp_collector
//
// Response-side companion to the MISR/SRAM address decoder. Every accepted
// request records its target, user field and write flag in an in-order tag
// FIFO. Each target (SRAM, MISR1, MISR2) has a one-entry holding register
// that captures its response. Responses are returned one per request, in
// issue order. Requests to unmapped MISR-region addresses complete without
// any target strobe and are flagged with rerr_o.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   request_i, wr_en_i        request strobe and its write flag
//   address_i, user_i         request address and user field
//   stall_o                   tag FIFO full; no request is accepted while high
//   sram_rvalid_i/rdata_i     SRAM response strobe and data
//   misr_rvalid_i[1:0]        MISR response strobes (bit0 MISR1, bit1 MISR2)
//   misr1_rdata_i/misr2_...   MISR read data, zero-extended on return
//   rvalid_o                  single-cycle response pulse toward AXI
//   rdata_o, ruser_o          response data and user field of the request
//   rwrite_o, rerr_o          request was a write / hit an unmapped address
//   ovf_o                     sticky spurious/overflowing target response flag

module misr_resp_collector #(
  parameter int          NBIT_MISR_DATA         = 32,
  parameter int          NBIT_AXI_WIDTH         = 64,
  parameter int          USER_AXI_WIDTH         = 10,
  parameter logic [63:0] MISR_PERIPH_START_ADDR = 64'h0000_0000_0200_0000,
  parameter int          DEPTH                  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      request_i,
  input  logic                      wr_en_i,
  input  logic [NBIT_AXI_WIDTH-1:0] address_i,
  input  logic [USER_AXI_WIDTH-1:0] user_i,
  output logic                      stall_o,
  input  logic                      sram_rvalid_i,
  input  logic [NBIT_AXI_WIDTH-1:0] sram_rdata_i,
  input  logic [1:0]                misr_rvalid_i,
  input  logic [NBIT_MISR_DATA-1:0] misr1_rdata_i,
  input  logic [NBIT_MISR_DATA-1:0] misr2_rdata_i,
  output logic                      rvalid_o,
  output logic [NBIT_AXI_WIDTH-1:0] rdata_o,
  output logic [USER_AXI_WIDTH-1:0] ruser_o,
  output logic                      rwrite_o,
  output logic                      rerr_o,
  output logic                      ovf_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [NBIT_AXI_WIDTH-1:0] MisrBase  = NBIT_AXI_WIDTH'(MISR_PERIPH_START_ADDR);
  localparam logic [NBIT_AXI_WIDTH-1:0] Misr2Addr = MisrBase + NBIT_AXI_WIDTH'(16);

  typedef enum logic [1:0] {
    TgtSram     = 2'd0,
    TgtMisr1    = 2'd1,
    TgtMisr2    = 2'd2,
    TgtUnmapped = 2'd3
  } target_e;

  target_e                   reqTgt;
  logic                      accept;
  logic                      pop;
  logic                      headReady;
  target_e                   headTgt;
  logic [USER_AXI_WIDTH-1:0] headUser;
  logic                      headWe;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outSram_q, outSram_d;
  logic [CW-1:0] outMisr1_q, outMisr1_d;
  logic [CW-1:0] outMisr2_q, outMisr2_d;

  target_e                   tagTgt_q  [DEPTH];
  logic [USER_AXI_WIDTH-1:0] tagUser_q [DEPTH];
  logic                      tagWe_q   [DEPTH];

  logic                      hvSram_q, hvSram_d;
  logic [NBIT_AXI_WIDTH-1:0] hdSram_q, hdSram_d;
  logic                      hvMisr1_q, hvMisr1_d;
  logic [NBIT_MISR_DATA-1:0] hdMisr1_q, hdMisr1_d;
  logic                      hvMisr2_q, hvMisr2_d;
  logic [NBIT_MISR_DATA-1:0] hdMisr2_q, hdMisr2_d;

  logic popSram, popMisr1, popMisr2;
  logic ovfSet;
  logic ovf_q;

  logic                      rvalid_q;
  logic [NBIT_AXI_WIDTH-1:0] rdata_q, rdata_d;
  logic [USER_AXI_WIDTH-1:0] ruser_q, ruser_d;
  logic                      rwrite_q, rwrite_d;
  logic                      rerr_q, rerr_d;

  assign stall_o = (count_q == CW'(DEPTH));
  assign accept  = request_i && !stall_o;

  // Classify the incoming address; everything at or above the MISR base
  // that is not one of the two registers is unmapped.
  always_comb begin
    if (address_i < MisrBase) begin
      reqTgt = TgtSram;
    end else if (address_i == MisrBase) begin
      reqTgt = TgtMisr1;
    end else if (address_i == Misr2Addr) begin
      reqTgt = TgtMisr2;
    end else begin
      reqTgt = TgtUnmapped;
    end
  end

  // The head entry may retire once its target's data is held; unmapped
  // entries need no data and retire as soon as they reach the head.
  always_comb begin
    headTgt  = tagTgt_q[rdPtr_q];
    headUser = tagUser_q[rdPtr_q];
    headWe   = tagWe_q[rdPtr_q];
    case (headTgt)
      TgtSram:  headReady = hvSram_q;
      TgtMisr1: headReady = hvMisr1_q;
      TgtMisr2: headReady = hvMisr2_q;
      default:  headReady = 1'b1;
    endcase
    pop = (count_q != '0) && headReady;
  end

  assign popSram  = pop && (headTgt == TgtSram);
  assign popMisr1 = pop && (headTgt == TgtMisr1);
  assign popMisr2 = pop && (headTgt == TgtMisr2);

  // Pointer, occupancy and per-target outstanding bookkeeping.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    outSram_d  = outSram_q;
    outMisr1_d = outMisr1_q;
    outMisr2_d = outMisr2_q;
    if (accept) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CW'(1);
    end
    if (accept && (reqTgt == TgtSram) && !popSram) begin
      outSram_d = outSram_q + CW'(1);
    end else if (popSram && !(accept && (reqTgt == TgtSram))) begin
      outSram_d = outSram_q - CW'(1);
    end
    if (accept && (reqTgt == TgtMisr1) && !popMisr1) begin
      outMisr1_d = outMisr1_q + CW'(1);
    end else if (popMisr1 && !(accept && (reqTgt == TgtMisr1))) begin
      outMisr1_d = outMisr1_q - CW'(1);
    end
    if (accept && (reqTgt == TgtMisr2) && !popMisr2) begin
      outMisr2_d = outMisr2_q + CW'(1);
    end else if (popMisr2 && !(accept && (reqTgt == TgtMisr2))) begin
      outMisr2_d = outMisr2_q - CW'(1);
    end
  end

  // Holding registers. A pop clears the entry first, so a strobe in the
  // same cycle reloads it. A strobe with nothing outstanding, or one that
  // would overwrite unconsumed data, is dropped and raises the error flag.
  always_comb begin
    hvSram_d  = hvSram_q;
    hdSram_d  = hdSram_q;
    hvMisr1_d = hvMisr1_q;
    hdMisr1_d = hdMisr1_q;
    hvMisr2_d = hvMisr2_q;
    hdMisr2_d = hdMisr2_q;
    ovfSet    = 1'b0;

    if (popSram) begin
      hvSram_d = 1'b0;
    end
    if (sram_rvalid_i) begin
      if ((outSram_q == '0) || (hvSram_q && !popSram)) begin
        ovfSet = 1'b1;
      end else begin
        hvSram_d = 1'b1;
        hdSram_d = sram_rdata_i;
      end
    end

    if (popMisr1) begin
      hvMisr1_d = 1'b0;
    end
    if (misr_rvalid_i[0]) begin
      if ((outMisr1_q == '0) || (hvMisr1_q && !popMisr1)) begin
        ovfSet = 1'b1;
      end else begin
        hvMisr1_d = 1'b1;
        hdMisr1_d = misr1_rdata_i;
      end
    end

    if (popMisr2) begin
      hvMisr2_d = 1'b0;
    end
    if (misr_rvalid_i[1]) begin
      if ((outMisr2_q == '0) || (hvMisr2_q && !popMisr2)) begin
        ovfSet = 1'b1;
      end else begin
        hvMisr2_d = 1'b1;
        hdMisr2_d = misr2_rdata_i;
      end
    end
  end

  // Response outputs only change on a pop and hold their value otherwise.
  always_comb begin
    rdata_d  = rdata_q;
    ruser_d  = ruser_q;
    rwrite_d = rwrite_q;
    rerr_d   = rerr_q;
    if (pop) begin
      ruser_d  = headUser;
      rwrite_d = headWe;
      rerr_d   = (headTgt == TgtUnmapped);
      case (headTgt)
        TgtSram:  rdata_d = hdSram_q;
        TgtMisr1: rdata_d = NBIT_AXI_WIDTH'(hdMisr1_q);
        TgtMisr2: rdata_d = NBIT_AXI_WIDTH'(hdMisr2_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  // Control state and outputs; reset drops every outstanding tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      outSram_q  <= '0;
      outMisr1_q <= '0;
      outMisr2_q <= '0;
      hvSram_q   <= 1'b0;
      hdSram_q   <= '0;
      hvMisr1_q  <= 1'b0;
      hdMisr1_q  <= '0;
      hvMisr2_q  <= 1'b0;
      hdMisr2_q  <= '0;
      ovf_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ruser_q    <= '0;
      rwrite_q   <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      outSram_q  <= outSram_d;
      outMisr1_q <= outMisr1_d;
      outMisr2_q <= outMisr2_d;
      hvSram_q   <= hvSram_d;
      hdSram_q   <= hdSram_d;
      hvMisr1_q  <= hvMisr1_d;
      hdMisr1_q  <= hdMisr1_d;
      hvMisr2_q  <= hvMisr2_d;
      hdMisr2_q  <= hdMisr2_d;
      ovf_q      <= ovf_q | ovfSet;
      rvalid_q   <= pop;
      rdata_q    <= rdata_d;
      ruser_q    <= ruser_d;
      rwrite_q   <= rwrite_d;
      rerr_q     <= rerr_d;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tagTgt_q[wrPtr_q]  <= reqTgt;
      tagUser_q[wrPtr_q] <= user_i;
      tagWe_q[wrPtr_q]   <= wr_en_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign ruser_o  = ruser_q;
  assign rwrite_o = rwrite_q;
  assign rerr_o   = rerr_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_misr_resp_collector.sv
// Testbench for misr_resp_collector. Directed stimulus; expected responses
// (data, user, write flag, error flag and the cycle they must appear in)
// are queued when stimulus is issued and checked by an independent monitor.

module tb_misr_resp_collector;

  localparam logic [63:0] Base = 64'h0000_0000_0200_0000;

  typedef struct {
    logic [63:0] data;
    logic [9:0]  user;
    logic        we;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request = 1'b0;
  logic        wrEn = 1'b0;
  logic [63:0] address = '0;
  logic [9:0]  user = '0;
  logic        stall;
  logic        sramRvalid = 1'b0;
  logic [63:0] sramRdata = '0;
  logic [1:0]  misrRvalid = '0;
  logic [31:0] misr1Rdata = '0;
  logic [31:0] misr2Rdata = '0;
  logic        rvalid;
  logic [63:0] rdata;
  logic [9:0]  ruser;
  logic        rwrite;
  logic        rerr;
  logic        ovf;

  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   t0;
  exp_t expQ[$];

  misr_resp_collector dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .request_i     (request),
    .wr_en_i       (wrEn),
    .address_i     (address),
    .user_i        (user),
    .stall_o       (stall),
    .sram_rvalid_i (sramRvalid),
    .sram_rdata_i  (sramRdata),
    .misr_rvalid_i (misrRvalid),
    .misr1_rdata_i (misr1Rdata),
    .misr2_rdata_i (misr2Rdata),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .ruser_o       (ruser),
    .rwrite_o      (rwrite),
    .rerr_o        (rerr),
    .ovf_o         (ovf)
  );

  always #5 clk = ~clk;

  // Cycle counter, read at the falling edge to time-stamp responses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge.
  task automatic applyStimulus(input logic req, input logic we, input logic [63:0] addr,
                               input logic [9:0] usr, input logic sv, input logic [63:0] sd,
                               input logic [1:0] mv, input logic [31:0] m1, input logic [31:0] m2);
    request    = req;
    wrEn       = we;
    address    = addr;
    user       = usr;
    sramRvalid = sv;
    sramRdata  = sd;
    misrRvalid = mv;
    misr1Rdata = m1;
    misr2Rdata = m2;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b00, '0, '0);
  endtask

  task automatic sendReq(input logic we, input logic [63:0] addr, input logic [9:0] usr);
    applyStimulus(1'b1, we, addr, usr, 1'b0, '0, 2'b00, '0, '0);
  endtask

  task automatic sramStrobe(input logic [63:0] d);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, d, 2'b00, '0, '0);
  endtask

  task automatic expectResp(input logic [63:0] d, input logic [9:0] u, input logic we,
                            input logic err, input int when);
    exp_t e;
    e.data = d;
    e.user = u;
    e.we   = we;
    e.err  = err;
    e.cyc  = when;
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"},  64'(stall),  64'd0);
    checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    checkOutput({tag, "_rdata"},  rdata,       64'd0);
    checkOutput({tag, "_ruser"},  64'(ruser),  64'd0);
    checkOutput({tag, "_rwrite"}, 64'(rwrite), 64'd0);
    checkOutput({tag, "_rerr"},   64'(rerr),   64'd0);
    checkOutput({tag, "_ovf"},    64'(ovf),    64'd0);
  endtask

  task automatic pulseReset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero(tag);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rvalid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_cycle",  64'(cyc),    64'(e.cyc));
        checkOutput("resp_rdata",  rdata,       e.data);
        checkOutput("resp_ruser",  64'(ruser),  64'(e.user));
        checkOutput("resp_rwrite", 64'(rwrite), 64'(e.we));
        checkOutput("resp_rerr",   64'(rerr),   64'(e.err));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    idle(2);

    $display("[TB] SRAM read");
    t0 = cyc;
    expectResp(64'hDEADBEEF_01234567, 10'h2A, 1'b0, 1'b0, t0 + 3);
    sendReq(1'b0, 64'h100, 10'h2A);
    sramStrobe(64'hDEADBEEF_01234567);
    idle(4);

    $display("[TB] ordering MISR1 then SRAM write");
    t0 = cyc;
    expectResp(64'h0000_0000_0000_1234, 10'h011, 1'b0, 1'b0, t0 + 9);
    expectResp(64'hCAFEF00D_0BADBEEF, 10'h022, 1'b1, 1'b0, t0 + 10);
    sendReq(1'b0, Base, 10'h011);
    sendReq(1'b1, 64'h8, 10'h022);
    sramStrobe(64'hCAFEF00D_0BADBEEF);
    idle(4);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b01, 32'h1234, '0);
    idle(5);

    $display("[TB] unmapped");
    t0 = cyc;
    expectResp(64'd0, 10'h033, 1'b0, 1'b1, t0 + 2);
    expectResp(64'd0, 10'h034, 1'b1, 1'b1, t0 + 3);
    sendReq(1'b0, Base + 64'd4, 10'h033);
    sendReq(1'b1, Base + 64'd8, 10'h034);
    idle(4);

    $display("[TB] full FIFO");
    t0 = cyc;
    expectResp(64'h1111, 10'h001, 1'b0, 1'b0, t0 + 7);
    expectResp(64'h2222, 10'h002, 1'b0, 1'b0, t0 + 10);
    expectResp(64'h3333, 10'h003, 1'b0, 1'b0, t0 + 11);
    expectResp(64'h4444, 10'h004, 1'b0, 1'b0, t0 + 12);
    expectResp(64'h5555, 10'h005, 1'b0, 1'b0, t0 + 13);
    sendReq(1'b0, 64'h300, 10'h001);
    sendReq(1'b0, 64'h308, 10'h002);
    sendReq(1'b0, 64'h310, 10'h003);
    sendReq(1'b0, 64'h318, 10'h004);
    checkOutput("stall_full", 64'(stall), 64'd1);
    sendReq(1'b0, 64'h400, 10'h005);
    applyStimulus(1'b1, 1'b0, 64'h400, 10'h005, 1'b1, 64'h1111, 2'b00, '0, '0);
    checkOutput("stall_held", 64'(stall), 64'd1);
    sendReq(1'b0, 64'h400, 10'h005);
    checkOutput("stall_released", 64'(stall), 64'd0);
    sendReq(1'b0, 64'h400, 10'h005);
    sramStrobe(64'h2222);
    sramStrobe(64'h3333);
    sramStrobe(64'h4444);
    sramStrobe(64'h5555);
    idle(4);
    checkOutput("ovf_clean", 64'(ovf), 64'd0);
    checkOutput("stall_idle", 64'(stall), 64'd0);

    $display("[TB] overflow");
    t0 = cyc;
    expectResp(64'h55, 10'h041, 1'b0, 1'b0, t0 + 6);
    expectResp(64'hAAAA_0000_AAAA_0000, 10'h042, 1'b0, 1'b0, t0 + 7);
    sendReq(1'b0, Base, 10'h041);
    sendReq(1'b0, 64'h500, 10'h042);
    sramStrobe(64'hAAAA_0000_AAAA_0000);
    checkOutput("ovf_before", 64'(ovf), 64'd0);
    sramStrobe(64'hBBBB_0000_BBBB_0000);
    checkOutput("ovf_overflow", 64'(ovf), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b01, 32'h55, '0);
    idle(5);

    $display("[TB] reset mid-operation");
    sendReq(1'b0, 64'h600, 10'h061);
    sendReq(1'b0, 64'h608, 10'h062);
    sendReq(1'b0, 64'h610, 10'h063);
    idle(1);
    pulseReset("midreset");
    sramStrobe(64'h6666);
    checkOutput("ovf_late_strobe", 64'(ovf), 64'd1);
    idle(3);
    checkOutput("stall_after_reset", 64'(stall), 64'd0);

    $display("[TB] spurious MISR2");
    pulseReset("reset2");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b10, '0, 32'h77);
    checkOutput("ovf_spurious", 64'(ovf), 64'd1);
    idle(3);
    checkOutput("ovf_sticky", 64'(ovf), 64'd1);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("responses_outstanding", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
